// File: rtl/accum_sched.sv
// Round-robin job scheduler sharing one external accumulator between NUM_REQ requesters.
// Optional signed-overflow tracking is compiled in when ACCUM_SCHED_OVF_EN is defined.
module accum_sched #(
    parameter int NUM_REQ    = 4,
    parameter int DIN_WIDTH  = 32,
    parameter int DOUT_WIDTH = 32,
    parameter int LEN_WIDTH  = 8
) (
    input  logic                            clk,
    input  logic                            rst_i,
    input  logic [NUM_REQ-1:0]              req_valid_i,
    input  logic [NUM_REQ*LEN_WIDTH-1:0]    req_len_i,
    output logic [NUM_REQ-1:0]              req_ready_o,
    input  logic [NUM_REQ-1:0]              dat_valid_i,
    input  logic [NUM_REQ*DIN_WIDTH-1:0]    dat_i,
    output logic [NUM_REQ-1:0]              dat_ready_o,
    output logic                            acc_en_o,
    output logic                            acc_clear_o,
    output logic [DIN_WIDTH-1:0]            acc_data_o,
    input  logic [DOUT_WIDTH-1:0]           acc_result_i,
    output logic                            res_valid_o,
    input  logic                            res_ready_i,
    output logic [$clog2(NUM_REQ)-1:0]      res_id_o,
    output logic [DOUT_WIDTH-1:0]           res_data_o,
    output logic                            res_ovf_o
);

    // state   | meaning
    // S_IDLE  | no job; grant the next requester in round-robin order
    // S_CLEAR | one-cycle accumulator clear for the granted job
    // S_RUN   | stream the granted requester's samples into the accumulator
    // S_WAIT  | let the last beat land in the accumulator, capture the sum
    // S_DONE  | present the tagged result until the consumer takes it

    localparam int ID_W = $clog2(NUM_REQ);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CLEAR = 3'd1,
        S_RUN   = 3'd2,
        S_WAIT  = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t                state, state_nxt;
    logic [ID_W-1:0]       rr_ptr;
    logic [ID_W-1:0]       gnt_id;
    logic [LEN_WIDTH-1:0]  count;
    logic [DOUT_WIDTH-1:0] res_data;
    logic                  ovf;

    logic                  pick_found;
    logic [ID_W-1:0]       pick_id;
    logic [LEN_WIDTH-1:0]  pick_len;
    int                    scan_slot;
    logic                  gnt_valid;
    logic [DIN_WIDTH-1:0]  gnt_dat;

    // First requesting slot at or after rr_ptr, wrapping at NUM_REQ.
    always_comb begin
        pick_found = 1'b0;
        pick_id    = '0;
        pick_len   = '0;
        scan_slot  = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            scan_slot = int'(rr_ptr) + i;
            if (scan_slot >= NUM_REQ) begin
                scan_slot = scan_slot - NUM_REQ;
            end
            for (int k = 0; k < NUM_REQ; k++) begin
                if (!pick_found && scan_slot == k && req_valid_i[k]) begin
                    pick_found = 1'b1;
                    pick_id    = ID_W'(k);
                    pick_len   = req_len_i[k*LEN_WIDTH +: LEN_WIDTH];
                end
            end
        end
    end

    always_comb begin
        gnt_valid = 1'b0;
        gnt_dat   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (gnt_id == ID_W'(k)) begin
                gnt_valid = dat_valid_i[k];
                gnt_dat   = dat_i[k*DIN_WIDTH +: DIN_WIDTH];
            end
        end
    end

    always_ff @(posedge clk or posedge rst_i) begin
        if (rst_i) begin
            state    <= S_IDLE;
            rr_ptr   <= '0;
            gnt_id   <= '0;
            count    <= '0;
            res_data <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                S_IDLE: begin
                    if (pick_found) begin
                        gnt_id <= pick_id;
                        count  <= pick_len;
                        if (pick_id == ID_W'(NUM_REQ - 1)) begin
                            rr_ptr <= '0;
                        end else begin
                            rr_ptr <= pick_id + 1'b1;
                        end
                    end
                end
                S_RUN: begin
                    if (gnt_valid) begin
                        count <= count - LEN_WIDTH'(1);
                    end
                end
                S_WAIT: begin
                    res_data <= acc_result_i;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_nxt   = state;
        req_ready_o = '0;
        dat_ready_o = '0;
        acc_en_o    = 1'b0;
        acc_clear_o = 1'b0;
        acc_data_o  = '0;
        res_valid_o = 1'b0;
        res_id_o    = '0;
        res_ovf_o   = 1'b0;
        case (state)
            S_IDLE: begin
                // Grant pulse is masked while reset is held so every output reads 0.
                if (pick_found && !rst_i) begin
                    req_ready_o = NUM_REQ'(1) << pick_id;
                    state_nxt   = S_CLEAR;
                end
            end
            S_CLEAR: begin
                acc_clear_o = 1'b1;
                state_nxt   = (count == '0) ? S_WAIT : S_RUN;
            end
            S_RUN: begin
                dat_ready_o = NUM_REQ'(1) << gnt_id;
                acc_en_o    = gnt_valid;
                acc_data_o  = gnt_dat;
                if (gnt_valid && count == LEN_WIDTH'(1)) begin
                    state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                state_nxt = S_DONE;
            end
            S_DONE: begin
                res_valid_o = 1'b1;
                res_id_o    = gnt_id;
                res_ovf_o   = ovf;
                if (res_ready_i) begin
                    state_nxt = S_IDLE;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    assign res_data_o = res_data;

`ifdef ACCUM_SCHED_OVF_EN
    logic [DOUT_WIDTH-1:0] ovf_addend;
    logic [DOUT_WIDTH-1:0] ovf_sum;
    logic                  ovf_hit;

    assign ovf_addend = DOUT_WIDTH'($signed(acc_data_o));
    assign ovf_sum    = acc_result_i + ovf_addend;
    assign ovf_hit    = (acc_result_i[DOUT_WIDTH-1] == ovf_addend[DOUT_WIDTH-1]) &&
                        (ovf_sum[DOUT_WIDTH-1] != acc_result_i[DOUT_WIDTH-1]);

    always_ff @(posedge clk or posedge rst_i) begin
        if (rst_i) begin
            ovf <= 1'b0;
        end else if (state == S_CLEAR) begin
            ovf <= 1'b0;
        end else if (state == S_RUN && acc_en_o && ovf_hit) begin
            ovf <= 1'b1;
        end
    end
`else
    assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_accum_sched.sv
// Bench for accum_sched: behavioural accumulator attached to the acc_* port, plus a
// round-robin / sum / overflow reference model computed from plain arithmetic.
module tb_accum_sched;

    localparam int NR = 4;
    localparam int DW = 32;
    localparam int OW = 32;
    localparam int LW = 8;
`ifdef ACCUM_SCHED_OVF_EN
    localparam bit OVF_ON = 1'b1;
`else
    localparam bit OVF_ON = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    logic [NR-1:0]    req_valid, req_ready, dat_valid, dat_ready;
    logic [NR*LW-1:0] req_len;
    logic [NR*DW-1:0] dat;
    logic             acc_en, acc_clear;
    logic [DW-1:0]    acc_data;
    logic [OW-1:0]    acc_result;
    logic             res_valid, res_ready, res_ovf;
    logic [1:0]       res_id;
    logic [OW-1:0]    res_data;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int en_cnt = 0, clr_cnt = 0, both_cnt = 0, multi_dat_rdy = 0;
    int model_rr = 0;

    always #5 clk = ~clk;

    accum_sched #(.NUM_REQ(NR), .DIN_WIDTH(DW), .DOUT_WIDTH(OW), .LEN_WIDTH(LW)) dut (
        .clk(clk), .rst_i(rst),
        .req_valid_i(req_valid), .req_len_i(req_len), .req_ready_o(req_ready),
        .dat_valid_i(dat_valid), .dat_i(dat), .dat_ready_o(dat_ready),
        .acc_en_o(acc_en), .acc_clear_o(acc_clear), .acc_data_o(acc_data),
        .acc_result_i(acc_result),
        .res_valid_o(res_valid), .res_ready_i(res_ready), .res_id_o(res_id),
        .res_data_o(res_data), .res_ovf_o(res_ovf)
    );

    // The shared accumulator the scheduler drives.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) acc_result <= '0;
        else if (acc_clear) acc_result <= '0;
        else if (acc_en) acc_result <= acc_result + OW'($signed(acc_data));
    end

    always @(posedge clk) begin
        cyc++;
        if (acc_en) en_cnt++;
        if (acc_clear) clr_cnt++;
        if (acc_en && acc_clear) both_cnt++;
        if ($countones(dat_ready) > 1) multi_dat_rdy++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic int model_pick(input logic [NR-1:0] m, input int ptr);
        for (int i = 0; i < NR; i++)
            if (m[(ptr + i) % NR]) return (ptr + i) % NR;
        return -1;
    endfunction

    function automatic logic [OW-1:0] model_sum(input logic [DW-1:0] q[$]);
        logic [OW-1:0] s = '0;
        foreach (q[i]) s = s + q[i];
        return s;
    endfunction

    function automatic bit model_ovf(input logic [DW-1:0] q[$]);
        longint r = 0;
        longint n;
        bit o = 1'b0;
        logic [31:0] w;
        foreach (q[i]) begin
            n = r + longint'($signed(q[i]));
            if (n > 64'sd2147483647 || n < -64'sd2147483648) o = 1'b1;
            w = n[31:0];
            r = longint'($signed(w));
        end
        return o;
    endfunction

    function automatic logic [DW-1:0] rand_sample();
        if ($urandom_range(0, 3) == 0) return $urandom();
        return DW'($urandom_range(0, 200)) - DW'(100);
    endfunction

    task automatic raise_req(input int id, input int len);
        req_valid[id] = 1'b1;
        req_len[id*LW +: LW] = LW'(len);
    endtask

    task automatic wait_grant(output int g, output int gcyc, output bit onehot, output bit to);
        g = -1; gcyc = 0; onehot = 1'b0; to = 1'b1;
        for (int k = 0; k < 200; k++) begin
            #1;
            if (req_ready != '0) begin
                to = 1'b0;
                gcyc = cyc;
                onehot = ($countones(req_ready) == 1);
                for (int i = 0; i < NR; i++) if (req_ready[i]) g = i;
                break;
            end
            @(negedge clk);
        end
        if (!to) begin
            @(negedge clk);
            req_valid[g] = 1'b0;
        end
    endtask

    task automatic stream(input int id, input logic [DW-1:0] s[$], input int gap, output bit to);
        int i = 0;
        int g = 0;
        for (int k = 0; k < 400 && i < s.size(); k++) begin
            if (g > 0) begin
                dat_valid[id] = 1'b0;
                g--;
            end else begin
                dat_valid[id] = 1'b1;
                dat[id*DW +: DW] = s[i];
            end
            if (dat_valid[id] && dat_ready[id]) begin
                i++;
                g = gap;
            end
            @(negedge clk);
        end
        dat_valid[id] = 1'b0;
        to = (i < s.size());
    endtask

    task automatic collect(input int rdy_delay, output int rid, output logic [OW-1:0] rdata,
                           output logic rovf, output int rcyc, output bit to, output int held_bad);
        to = 1'b1; held_bad = 0; rid = -1; rdata = '0; rovf = 1'b0; rcyc = 0;
        for (int k = 0; k < 400; k++) begin
            if (res_valid) begin
                to = 1'b0;
                break;
            end
            @(negedge clk);
        end
        if (!to) begin
            rcyc = cyc; rid = int'(res_id); rdata = res_data; rovf = res_ovf;
            for (int k = 0; k < rdy_delay; k++) begin
                @(negedge clk);
                if (!res_valid || res_data !== rdata || req_ready != '0) held_bad++;
            end
            res_ready = 1'b1;
            @(negedge clk);
            res_ready = 1'b0;
        end
    endtask

    task automatic do_job(input int id, input int len, input logic [DW-1:0] q[$], input int gap,
                          input int rdy, output int g, output int lat, output int rid,
                          output logic [OW-1:0] rd, output logic ro, output bit to, output int hb);
        int gc, rc;
        bit t1, t2, t3, oh;
        raise_req(id, len);
        wait_grant(g, gc, oh, t1);
        t2 = 1'b0; t3 = 1'b0; rid = -1; rd = '0; ro = 1'b0; hb = 0; lat = 0;
        if (!t1) begin
            stream(id, q, gap, t2);
            collect(rdy, rid, rd, ro, rc, t3, hb);
            lat = rc - gc;
        end
        to = t1 | t2 | t3;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        #1;
        tests++;
        if ({req_ready, dat_ready, acc_en, acc_clear, acc_data, res_valid, res_id, res_data, res_ovf} !== '0) begin
            fails++;
            $display("FAIL reset_outputs: got rdy=%b dr=%b en=%b clr=%b res_v=%b data=%h want all 0",
                     req_ready, dat_ready, acc_en, acc_clear, res_valid, res_data);
        end
        req_valid[2] = 1'b1;
        #1;
        tests++;
        if (req_ready !== '0) begin
            fails++;
            $display("FAIL reset_no_grant: got req_ready=%b want 0000", req_ready);
        end
        req_valid = '0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        model_rr = 0;
    endtask

    task automatic test_single_job();
        logic [DW-1:0] q[$];
        int g, lat, rid, hb, e0, c0, b0, expg;
        logic [OW-1:0] rd;
        logic ro;
        bit to;
        q = '{32'd1, 32'd2, 32'd3, 32'd4};
        e0 = en_cnt; c0 = clr_cnt; b0 = both_cnt;
        expg = model_pick(4'b0001, model_rr);
        do_job(0, 4, q, 0, 0, g, lat, rid, rd, ro, to, hb);
        model_rr = (expg + 1) % NR;
        tests++;
        if (to) begin fails++; $display("FAIL single_timeout: got timeout want completion"); end
        tests++;
        if (g !== expg || rid !== expg) begin
            fails++; $display("FAIL single_id: got grant=%0d res_id=%0d want %0d", g, rid, expg);
        end
        tests++;
        if (rd !== 32'd10) begin fails++; $display("FAIL single_sum: got %0d want 10", rd); end
        tests++;
        if (lat !== 7) begin fails++; $display("FAIL single_latency: got %0d want 7", lat); end
        tests++;
        if (en_cnt - e0 !== 4 || clr_cnt - c0 !== 1 || both_cnt != b0) begin
            fails++; $display("FAIL single_pulses: got en=%0d clr=%0d both=%0d want 4 1 0",
                              en_cnt - e0, clr_cnt - c0, both_cnt - b0);
        end
        tests++;
        if (ro !== 1'b0) begin fails++; $display("FAIL single_ovf: got %b want 0", ro); end
    endtask

    task automatic test_rr_fairness();
        int exp_g[$];
        int got_g[$];
        int res_i[$];
        logic [OW-1:0] res_d[$];
        int e;
        for (int k = 0; k < NR; k++) begin
            req_len[k*LW +: LW] = LW'(1);
            dat[k*DW +: DW] = DW'(k + 1);
        end
        dat_valid = '1;
        req_valid = '1;
        res_ready = 1'b1;
        for (int k = 0; k < 300 && res_i.size() < 8; k++) begin
            #1;
            if (req_ready != '0) begin
                e = model_pick(4'b1111, model_rr);
                model_rr = (e + 1) % NR;
                exp_g.push_back(e);
                for (int i = 0; i < NR; i++) if (req_ready[i]) got_g.push_back(i);
                tests++;
                if (req_ready !== (4'b0001 << e)) begin
                    fails++; $display("FAIL rr_grant: got req_ready=%b want grant %0d", req_ready, e);
                end
            end
            if (res_valid) begin
                res_i.push_back(int'(res_id));
                res_d.push_back(res_data);
                if (res_i.size() == 8) begin
                    req_valid = '0;
                    dat_valid = '0;
                end
            end
            @(negedge clk);
        end
        res_ready = 1'b0;
        tests++;
        if (res_i.size() != 8 || exp_g.size() != 8) begin
            fails++; $display("FAIL rr_count: got %0d results %0d grants want 8 8", res_i.size(), exp_g.size());
        end
        for (int i = 0; i < res_i.size() && i < exp_g.size(); i++) begin
            tests++;
            if (res_i[i] !== exp_g[i] || res_d[i] !== OW'(exp_g[i] + 1)) begin
                fails++; $display("FAIL rr_result: got id=%0d data=%0d want id=%0d data=%0d",
                                  res_i[i], res_d[i], exp_g[i], exp_g[i] + 1);
            end
        end
    endtask

    task automatic test_signed_stall();
        logic [DW-1:0] q[$];
        int g, lat, rid, hb, e0;
        logic [OW-1:0] rd;
        logic ro;
        bit to;
        q = '{32'hFFFF_FFFB, 32'd3, 32'hFFFF_FFFF};
        e0 = en_cnt;
        do_job(2, 3, q, 2, 0, g, lat, rid, rd, ro, to, hb);
        model_rr = 3;
        tests++;
        if (to || rid !== 2) begin fails++; $display("FAIL stall_id: got id=%0d timeout=%b want 2 0", rid, to); end
        tests++;
        if (rd !== 32'hFFFF_FFFD) begin fails++; $display("FAIL stall_sum: got %h want fffffffd", rd); end
        tests++;
        if (en_cnt - e0 !== 3) begin fails++; $display("FAIL stall_en: got %0d want 3", en_cnt - e0); end
    endtask

    task automatic test_len0_backpressure();
        logic [DW-1:0] q[$];
        int g, gc, rid, rc, hb, hs_cyc, e0, expg;
        logic [OW-1:0] rd;
        logic ro;
        bit t1, t2, t3, oh;
        e0 = en_cnt;
        raise_req(1, 0);
        wait_grant(g, gc, oh, t1);
        model_rr = (model_pick(4'b0010, model_rr) + 1) % NR;
        raise_req(0, 2);
        collect(5, rid, rd, ro, rc, t3, hb);
        hs_cyc = cyc;
        tests++;
        if (t1 || t3 || rid !== 1 || rd !== '0) begin
            fails++; $display("FAIL len0_result: got id=%0d data=%h to=%b%b want 1 0", rid, rd, t1, t3);
        end
        tests++;
        if (hb !== 0) begin fails++; $display("FAIL len0_hold: got %0d bad hold cycles want 0", hb); end
        tests++;
        if (rc - gc !== 3 || en_cnt != e0) begin
            fails++; $display("FAIL len0_latency: got lat=%0d en=%0d want 3 0", rc - gc, en_cnt - e0);
        end
        expg = model_pick(4'b0001, model_rr);
        model_rr = (expg + 1) % NR;
        wait_grant(g, gc, oh, t1);
        tests++;
        if (t1 || g !== expg || gc !== hs_cyc) begin
            fails++; $display("FAIL b2b_grant: got g=%0d cyc=%0d want g=%0d cyc=%0d", g, gc, expg, hs_cyc);
        end
        q = '{32'd20, 32'd22};
        stream(0, q, 0, t2);
        collect(0, rid, rd, ro, rc, t3, hb);
        tests++;
        if (t2 || t3 || rid !== 0 || rd !== 32'd42) begin
            fails++; $display("FAIL b2b_result: got id=%0d data=%0d want 0 42", rid, rd);
        end
    endtask

    task automatic test_reset_mid_run();
        logic [DW-1:0] q[$];
        int g, gc, rid, rc, hb, seen, lat, expg;
        logic [OW-1:0] rd;
        logic ro;
        bit t1, t2, oh, to;
        raise_req(1, 4);
        wait_grant(g, gc, oh, t1);
        q = '{32'd7, 32'd8};
        stream(1, q, 0, t2);
        rst = 1'b1;
        req_valid[2] = 1'b1;
        #1;
        tests++;
        if ({req_ready, dat_ready, acc_en, acc_clear, acc_data, res_valid, res_id, res_ovf} !== '0) begin
            fails++; $display("FAIL rst_mid_outputs: got rdy=%b dr=%b en=%b clr=%b res_v=%b want all 0",
                              req_ready, dat_ready, acc_en, acc_clear, res_valid);
        end
        req_valid = '0;
        @(negedge clk);
        rst = 1'b0;
        model_rr = 0;
        seen = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (res_valid) seen++;
        end
        tests++;
        if (seen !== 0) begin fails++; $display("FAIL rst_mid_noresult: got %0d result cycles want 0", seen); end
        raise_req(3, 2);
        expg = model_pick(4'b1001, model_rr);
        model_rr = (expg + 1) % NR;
        q = '{32'd5, 32'd6};
        do_job(0, 2, q, 0, 0, g, lat, rid, rd, ro, to, hb);
        tests++;
        if (to || g !== expg || rid !== expg || rd !== 32'd11) begin
            fails++; $display("FAIL rst_mid_next: got g=%0d id=%0d data=%0d want %0d %0d 11", g, rid, rd, expg, expg);
        end
        q = '{32'd100, 32'd1};
        do_job(3, 2, q, 0, 0, g, lat, rid, rd, ro, to, hb);
        model_rr = 0;
        tests++;
        if (to || rid !== 3 || rd !== 32'd101) begin
            fails++; $display("FAIL rst_mid_pending: got id=%0d data=%0d want 3 101", rid, rd);
        end
    endtask

    task automatic test_ovf();
        logic [DW-1:0] q[$];
        int g, lat, rid, hb;
        logic [OW-1:0] rd;
        logic ro;
        bit to;
        q = '{32'h7FFF_FFFF, 32'd1};
        do_job(0, 2, q, 0, 0, g, lat, rid, rd, ro, to, hb);
        model_rr = 1;
        tests++;
        if (to || rd !== 32'h8000_0000 || ro !== OVF_ON) begin
            fails++; $display("FAIL ovf_set: got data=%h ovf=%b want 80000000 %b", rd, ro, OVF_ON);
        end
        q = '{32'd1, 32'd1};
        do_job(0, 2, q, 0, 0, g, lat, rid, rd, ro, to, hb);
        tests++;
        if (to || rd !== 32'd2 || ro !== 1'b0) begin
            fails++; $display("FAIL ovf_clear: got data=%h ovf=%b want 2 0", rd, ro);
        end
    endtask

    task automatic test_random();
        logic [DW-1:0] q[$];
        logic [NR-1:0] pend;
        int lens[NR];
        int g, gc, rid, rc, hb, expg, gap, rdy, e0, c0;
        logic [OW-1:0] rd;
        logic ro;
        bit t1, t2, t3, oh;
        pend = '0;
        for (int it = 0; it < 12; it++) begin
            for (int k = 0; k < NR; k++) begin
                if (!pend[k] && $urandom_range(0, 1) == 1) begin
                    lens[k] = $urandom_range(0, 5);
                    raise_req(k, lens[k]);
                    pend[k] = 1'b1;
                end
            end
            if (pend == '0) begin
                lens[it % NR] = $urandom_range(0, 5);
                raise_req(it % NR, lens[it % NR]);
                pend[it % NR] = 1'b1;
            end
            e0 = en_cnt; c0 = clr_cnt;
            expg = model_pick(pend, model_rr);
            model_rr = (expg + 1) % NR;
            wait_grant(g, gc, oh, t1);
            tests++;
            if (t1 || !oh || g !== expg) begin
                fails++; $display("FAIL rand_grant: got g=%0d onehot=%b to=%b want %0d", g, oh, t1, expg);
                break;
            end
            pend[g] = 1'b0;
            q.delete();
            for (int i = 0; i < lens[g]; i++) q.push_back(rand_sample());
            gap = $urandom_range(0, 2);
            rdy = $urandom_range(0, 3);
            stream(g, q, gap, t2);
            collect(rdy, rid, rd, ro, rc, t3, hb);
            tests++;
            if (t2 || t3 || rid !== g || rd !== model_sum(q) || ro !== (OVF_ON & model_ovf(q))) begin
                fails++; $display("FAIL rand_result: got id=%0d data=%h ovf=%b want id=%0d data=%h ovf=%b",
                                  rid, rd, ro, g, model_sum(q), OVF_ON & model_ovf(q));
            end
            tests++;
            if (hb !== 0 || en_cnt - e0 !== lens[g] || clr_cnt - c0 !== 1 ||
                (gap == 0 && rc - gc !== 3 + lens[g])) begin
                fails++; $display("FAIL rand_timing: got hold_bad=%0d en=%0d clr=%0d lat=%0d want 0 %0d 1 %0d",
                                  hb, en_cnt - e0, clr_cnt - c0, rc - gc, lens[g], 3 + lens[g]);
            end
        end
        req_valid = '0;
        @(negedge clk);
        tests++;
        if (both_cnt !== 0 || multi_dat_rdy !== 0) begin
            fails++; $display("FAIL exclusivity: got both=%0d multi_dat_ready=%0d want 0 0", both_cnt, multi_dat_rdy);
        end
    endtask

    initial begin
        rst = 1'b1;
        req_valid = '0;
        req_len = '0;
        dat_valid = '0;
        dat = '0;
        res_ready = 1'b0;
        test_reset();
        test_single_job();
        test_rr_fairness();
        test_signed_stall();
        test_len0_backpressure();
        test_reset_mid_run();
        test_ovf();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
